// File: rtl/bitpattern_pkg.sv
// bitpattern_pkg: shared definitions for the serial bit-pattern transmitter
// and the recogniser it drives.
//   DEFAULT_WIDTH          default pattern length in bits
//   PATTERN_101            canonical 3-bit test pattern
//   bitpattern_tx_state_t  transmitter FSM state encoding
package bitpattern_pkg;

  localparam int DEFAULT_WIDTH = 3;

  localparam logic [2:0] PATTERN_101 = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } bitpattern_tx_state_t;

endpackage

// File: rtl/bitpattern_tx.sv
// bitpattern_tx: serial bit-pattern transmitter. On start it latches a
// WIDTH-bit pattern and a repeat count, then shifts the pattern out MSB-first,
// one bit per clock, (repeats+1) times with GAP idle cycles between passes.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   start      transmit request, sampled only while busy = 0
//   pattern    WIDTH bits to send, bit WIDTH-1 first
//   repeats    extra transmissions (total = repeats + 1)
//   outp       serial line (feeds the recogniser input)
//   valid      outp carries a pattern bit
//   busy       high from the first bit through the last bit or gap
//   done       one-cycle pulse in the cycle after the final bit
//   state_dbg  current FSM state
//
// Handshake: start acts as a request that is taken on any rising edge where
// the FSM is in IDLE or DONE (busy = 0) and reset is low; pattern and repeats
// are captured on that same edge and later changes are ignored. There is no
// back-pressure: once accepted, the job runs to completion or reset.
module bitpattern_tx
  import bitpattern_pkg::bitpattern_tx_state_t;
  import bitpattern_pkg::DEFAULT_WIDTH;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     pattern,
  input  logic [3:0]           repeats,
  output logic                 outp,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output bitpattern_tx_state_t state_dbg
);

  if (WIDTH < 2) begin : g_width_check
    $error("bitpattern_tx: WIDTH must be at least 2");
  end

  localparam int BW = $clog2(WIDTH);

  bitpattern_tx_state_t state;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     pat_q;
  logic [3:0]           rep_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_last;
  logic                 gap_last;

  assign bit_last  = (bit_cnt == BW'(WIDTH - 1));
  assign state_dbg = state;

  // shreg is zero in every state except SHIFT (zeros are shifted in and it
  // is cleared on leaving), so its MSB is directly the registered line.
  assign outp = shreg[WIDTH-1];

  // The gap counter only exists when a gap is configured; it runs while in
  // GAP and is held at zero everywhere else.
  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clock) begin
      if (reset || (state != bitpattern_pkg::GAP)) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end

    assign gap_last = (gap_cnt == GW'(GAP - 1));
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= bitpattern_pkg::IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new job exactly like IDLE so jobs can run back-to-back.
        bitpattern_pkg::IDLE, bitpattern_pkg::DONE: begin
          if (start) begin
            state   <= bitpattern_pkg::SHIFT;
            shreg   <= pattern;
            pat_q   <= pattern;
            rep_cnt <= repeats;
            bit_cnt <= '0;
            valid   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state   <= bitpattern_pkg::IDLE;
            shreg   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
          end
        end

        bitpattern_pkg::SHIFT: begin
          if (!bit_last) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (rep_cnt == 4'd0) begin
            state <= bitpattern_pkg::DONE;
            shreg <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // Another pass follows; the repeat count only moves here, so it
            // can never wrap below zero.
            rep_cnt <= rep_cnt - 4'd1;
            if (GAP > 0) begin
              state <= bitpattern_pkg::GAP;
              shreg <= '0;
              valid <= 1'b0;
            end else begin
              shreg   <= pat_q;
              bit_cnt <= '0;
            end
          end
        end

        bitpattern_pkg::GAP: begin
          if (gap_last) begin
            state   <= bitpattern_pkg::SHIFT;
            shreg   <= pat_q;
            bit_cnt <= '0;
            valid   <= 1'b1;
          end
        end

        default: begin
          state <= bitpattern_pkg::IDLE;
          shreg <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitpattern_tx.sv
// tb_bitpattern_tx: directed bench for bitpattern_tx. Two instances share
// clock and reset: u_gap1 (GAP = 1) and u_gap0 (GAP = 0). Each directed job
// is a table of per-cycle entries: the expected {outp,valid,busy,done} seen
// in that cycle and the start/pattern/repeats driven on the following edge.
module tb_bitpattern_tx;
  import bitpattern_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                 start1, start0;
  logic [W-1:0]         pat1, pat0;
  logic [3:0]           rep1, rep0;
  logic                 outp1, valid1, busy1, done1;
  logic                 outp0, valid0, busy0, done0;
  bitpattern_tx_state_t st1, st0;

  bitpattern_tx #(.WIDTH(W), .GAP(1)) u_gap1 (
    .clock     (clock),
    .reset     (reset),
    .start     (start1),
    .pattern   (pat1),
    .repeats   (rep1),
    .outp      (outp1),
    .valid     (valid1),
    .busy      (busy1),
    .done      (done1),
    .state_dbg (st1)
  );

  bitpattern_tx #(.WIDTH(W), .GAP(0)) u_gap0 (
    .clock     (clock),
    .reset     (reset),
    .start     (start0),
    .pattern   (pat0),
    .repeats   (rep0),
    .outp      (outp0),
    .valid     (valid0),
    .busy      (busy0),
    .done      (done0),
    .state_dbg (st0)
  );

  // ---------------- recogniser model (non-overlapping 101) ----------------
  logic [1:0] rec_s;
  int         det_cnt;
  logic       rec_clr;

  always @(posedge clock) begin
    if (reset || rec_clr) begin
      rec_s   <= 2'd0;
      det_cnt <= 0;
    end else begin
      case (rec_s)
        2'd0:    rec_s <= outp1 ? 2'd1 : 2'd0;
        2'd1:    rec_s <= outp1 ? 2'd1 : 2'd2;
        default: begin
          if (outp1) det_cnt <= det_cnt + 1;
          rec_s <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         start;
    logic [W-1:0] pat;
    logic [3:0]   rep;
  } drv_t;

  logic [3:0] exp_q[$];
  drv_t       drv_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int sel);
    if (sel == 1) return {4'b0, outp1, valid1, busy1, done1};
    else          return {4'b0, outp0, valid0, busy0, done0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic [3:0] e, input logic s, input logic [W-1:0] p,
                     input logic [3:0] r);
    drv_t d;
    d.start = s;
    d.pat   = p;
    d.rep   = r;
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  // One pass of pattern p on the line: each bit with valid = busy = 1.
  task automatic add_pass(input logic [W-1:0] p, input logic [3:0] r);
    for (int b = W - 1; b >= 0; b--) add({p[b], 3'b110}, 1'b0, p, r);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run(input int sel, input string name);
    logic [3:0] e;
    drv_t       d;
    int         i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      check($sformatf("%s[%0d]", name, i), obs(sel), {4'b0, e});
      if (sel == 1) begin
        start1 = d.start; pat1 = d.pat; rep1 = d.rep;
      end else begin
        start0 = d.start; pat0 = d.pat; rep0 = d.rep;
      end
      i++;
      @(negedge clock);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start1 = 1'b0; pat1 = '0; rep1 = '0;
    start0 = 1'b0; pat0 = '0; rep0 = '0;
    rec_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_out_gap1",   obs(1), 8'h00);
    check("reset_state_gap1", {6'b0, st1}, {6'b0, IDLE});
    check("reset_out_gap0",   obs(0), 8'h00);
    reset = 1'b0;
    @(negedge clock);

    // Single shot: 101, repeats 0.
    add(4'b0000, 1'b1, PATTERN_101, 4'd0);
    add_pass(PATTERN_101, 4'd0);
    add(4'b0001, 1'b0, PATTERN_101, 4'd0);
    add(4'b0000, 1'b0, PATTERN_101, 4'd0);
    run(1, "single");

    // Repeats with a one-cycle gap: 101 0 101 0 101, 11 busy cycles.
    add(4'b0000, 1'b1, PATTERN_101, 4'd2);
    add_pass(PATTERN_101, 4'd2);
    add(4'b0010, 1'b0, PATTERN_101, 4'd2);
    add_pass(PATTERN_101, 4'd2);
    add(4'b0010, 1'b0, PATTERN_101, 4'd2);
    add_pass(PATTERN_101, 4'd2);
    add(4'b0001, 1'b0, PATTERN_101, 4'd2);
    add(4'b0000, 1'b0, PATTERN_101, 4'd2);
    run(1, "rep_gap");

    // Back-to-back with no gap, then restart from DONE with 101.
    add(4'b0000, 1'b1, 3'b110, 4'd1);
    add_pass(3'b110, 4'd1);
    add_pass(3'b110, 4'd1);
    add(4'b0001, 1'b1, PATTERN_101, 4'd0);
    add_pass(PATTERN_101, 4'd0);
    add(4'b0001, 1'b0, PATTERN_101, 4'd0);
    add(4'b0000, 1'b0, PATTERN_101, 4'd0);
    run(0, "b2b");

    // start held high; pattern and repeats change while busy.
    add(4'b0000, 1'b1, PATTERN_101, 4'd0);
    add(4'b1110, 1'b1, PATTERN_101, 4'd0);
    add(4'b0110, 1'b1, 3'b011,      4'd2);
    add(4'b1110, 1'b1, 3'b011,      4'd0);
    add(4'b0001, 1'b1, 3'b011,      4'd0);
    add(4'b0110, 1'b0, 3'b011,      4'd0);
    add(4'b1110, 1'b0, 3'b011,      4'd0);
    add(4'b1110, 1'b0, 3'b011,      4'd0);
    add(4'b0001, 1'b0, 3'b011,      4'd0);
    add(4'b0000, 1'b0, 3'b011,      4'd0);
    run(1, "busy_ign");

    // Reset mid-SHIFT, held two cycles, with start high during reset.
    start1 = 1'b1; pat1 = PATTERN_101; rep1 = 4'd3;
    @(negedge clock);
    start1 = 1'b0;
    check("rst_mid_b0", obs(1), 8'h0e);
    @(negedge clock);
    check("rst_mid_b1", obs(1), 8'h06);
    reset = 1'b1;
    start1 = 1'b1;
    @(negedge clock);
    check("rst_hold1_out",   obs(1), 8'h00);
    check("rst_hold1_state", {6'b0, st1}, {6'b0, IDLE});
    @(negedge clock);
    check("rst_hold2_out", obs(1), 8'h00);
    reset = 1'b0;
    start1 = 1'b0;
    @(negedge clock);
    check("rst_after_out",   obs(1), 8'h00);
    check("rst_after_state", {6'b0, st1}, {6'b0, IDLE});

    // End-to-end: 101 x4 with gap 1 into the recogniser model.
    rec_clr = 1'b1;
    @(negedge clock);
    rec_clr = 1'b0;
    add(4'b0000, 1'b1, PATTERN_101, 4'd3);
    for (int k = 0; k < 3; k++) begin
      add_pass(PATTERN_101, 4'd3);
      add(4'b0010, 1'b0, PATTERN_101, 4'd3);
    end
    add_pass(PATTERN_101, 4'd3);
    add(4'b0001, 1'b0, PATTERN_101, 4'd3);
    add(4'b0000, 1'b0, PATTERN_101, 4'd3);
    run(1, "e2e");
    check("e2e_detects", det_cnt[7:0], 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
